batch_controller: RTL and testbench

BATCH_CONTROLLER -- requirements
Module: batch_controller

---
 rtl/batch_controller_pkg.sv | 27 ++
 rtl/batch_controller_if.sv | 33 +++
 rtl/batch_controller_axis_reg_slice.sv | 39 +++
 rtl/batch_controller.sv | 152 +++++++++++++++
 tb/tb_batch_controller.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/batch_controller_pkg.sv
// Shared scheduler definitions: batch controller FSM encoding, counter widths
// and the transaction/program-ID types shared with the conflict checker.
package batch_controller_pkg;

    localparam int CNT16_W   = 16;
    localparam int CNT32_W   = 32;
    localparam int PROG_ID_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COLLECT   = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_WAIT_EXEC = 2'd3
    } batch_state_e;

    // Conflict checker verdict on an incoming transaction.
    typedef enum logic [0:0] {
        CC_CLEAR    = 1'b0,
        CC_CONFLICT = 1'b1
    } conflict_result_e;

    // Only an empty or filling batch may take new transactions.
    function automatic logic state_accepts(input batch_state_e st);
        return (st == ST_IDLE) || (st == ST_COLLECT);
    endfunction

endpackage

// File: rtl/batch_controller_if.sv
// Stream handshake bundle between the conflict checker, the batch controller
// and the execution queue.
interface batch_controller_if;
    import batch_controller_pkg::*;

    logic                 s_axis_tvalid;
    logic                 s_axis_tready;
    logic [PROG_ID_W-1:0] s_axis_tdata_owner_programID;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic [PROG_ID_W-1:0] m_axis_tdata_owner_programID;

    // Controller side.
    modport slave (
        input  s_axis_tvalid,
        input  s_axis_tdata_owner_programID,
        output s_axis_tready,
        output m_axis_tvalid,
        output m_axis_tdata_owner_programID,
        input  m_axis_tready
    );

    // Environment side: drives the ingress stream, sinks the egress stream.
    modport master (
        output s_axis_tvalid,
        output s_axis_tdata_owner_programID,
        input  s_axis_tready,
        input  m_axis_tvalid,
        input  m_axis_tdata_owner_programID,
        output m_axis_tready
    );

endinterface

// File: rtl/batch_controller_axis_reg_slice.sv
// Single-entry output register for the batch controller egress stream;
// holds data stable while the consumer back-pressures.
module axis_reg_slice
    import batch_controller_pkg::*;
#(
    parameter int DATA_W = PROG_ID_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    logic              valid_r;
    logic [DATA_W-1:0] data_r;

    // A load in the same cycle as a handshake keeps the slot full at one beat per cycle.
    assign in_ready  = !valid_r || out_ready;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Slot fill/drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
        end else if (in_valid && in_ready) begin
            valid_r <= 1'b1;
            data_r  <= in_data;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end
    end

endmodule

// File: rtl/batch_controller.sv
// Groups conflict-free transactions into batches closed by size, idle timeout
// or flush, and hands each closed batch to the execution engine.
module batch_controller
    import batch_controller_pkg::*;
#(
    parameter int BATCH_SIZE     = 8,
    parameter int TIMEOUT_CYCLES = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    batch_controller_if.slave  axis,
    input  logic               flush,
    input  logic               exec_done,
    output logic               batch_completed,
    output logic [CNT32_W-1:0] batch_id,
    output logic [CNT16_W-1:0] batch_count,
    output logic [CNT32_W-1:0] timeout_closes,
    output logic [CNT32_W-1:0] total_batches
);

    localparam logic [CNT16_W-1:0] BATCH_SIZE_C   = CNT16_W'(BATCH_SIZE);
    localparam logic [CNT16_W-1:0] TIMEOUT_LAST_C = CNT16_W'(TIMEOUT_CYCLES - 1);

    batch_state_e       state_r;
    logic [CNT16_W-1:0] cur_count_r;
    logic [CNT16_W-1:0] idle_cnt_r;
    logic               ready_en_r;
    logic               close_timeout_r;
    logic               batch_completed_r;
    logic [CNT32_W-1:0] batch_id_r;
    logic [CNT16_W-1:0] batch_count_r;
    logic [CNT32_W-1:0] timeout_closes_r;
    logic [CNT32_W-1:0] total_batches_r;

    logic                 accept_s;
    logic                 slice_in_ready_s;
    logic                 out_valid_s;
    logic [PROG_ID_W-1:0] out_data_s;
    logic                 out_empty_s;
    logic [CNT16_W-1:0]   cur_count_inc_s;

    // ready_en_r tracks the FSM side so only the back-pressure term is combinational.
    assign axis.s_axis_tready = ready_en_r && slice_in_ready_s;
    assign accept_s           = axis.s_axis_tvalid && axis.s_axis_tready;
    assign out_empty_s        = !out_valid_s || axis.m_axis_tready;
    assign cur_count_inc_s    = cur_count_r + 16'd1;

    assign axis.m_axis_tvalid                = out_valid_s;
    assign axis.m_axis_tdata_owner_programID = out_data_s;

    assign batch_completed = batch_completed_r;
    assign batch_id        = batch_id_r;
    assign batch_count     = batch_count_r;
    assign timeout_closes  = timeout_closes_r;
    assign total_batches   = total_batches_r;

    axis_reg_slice #(
        .DATA_W (PROG_ID_W)
    ) u_out_slice (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept_s),
        .in_data   (axis.s_axis_tdata_owner_programID),
        .in_ready  (slice_in_ready_s),
        .out_valid (out_valid_s),
        .out_data  (out_data_s),
        .out_ready (axis.m_axis_tready)
    );

    // Batch FSM, batch bookkeeping and close statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r           <= ST_IDLE;
            cur_count_r       <= 16'd0;
            idle_cnt_r        <= 16'd0;
            ready_en_r        <= 1'b0;
            close_timeout_r   <= 1'b0;
            batch_completed_r <= 1'b0;
            batch_id_r        <= 32'd0;
            batch_count_r     <= 16'd0;
            timeout_closes_r  <= 32'd0;
            total_batches_r   <= 32'd0;
        end else begin
            batch_completed_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    ready_en_r <= 1'b1;
                    if (accept_s) begin
                        cur_count_r <= 16'd1;
                        idle_cnt_r  <= 16'd0;
                        if (BATCH_SIZE_C == 16'd1) begin
                            state_r         <= ST_DRAIN;
                            ready_en_r      <= 1'b0;
                            close_timeout_r <= 1'b0;
                        end else begin
                            state_r <= ST_COLLECT;
                        end
                    end
                end

                ST_COLLECT: begin
                    // An accept always wins over timeout and flush on the same cycle.
                    if (accept_s) begin
                        cur_count_r <= cur_count_inc_s;
                        idle_cnt_r  <= 16'd0;
                        if (cur_count_inc_s == BATCH_SIZE_C) begin
                            state_r         <= ST_DRAIN;
                            ready_en_r      <= 1'b0;
                            close_timeout_r <= 1'b0;
                        end
                    end else if (idle_cnt_r == TIMEOUT_LAST_C) begin
                        state_r         <= ST_DRAIN;
                        ready_en_r      <= 1'b0;
                        close_timeout_r <= 1'b1;
                    end else if (flush) begin
                        state_r         <= ST_DRAIN;
                        ready_en_r      <= 1'b0;
                        close_timeout_r <= 1'b0;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + 16'd1;
                    end
                end

                ST_DRAIN: begin
                    if (out_empty_s) begin
                        batch_completed_r <= 1'b1;
                        batch_count_r     <= cur_count_r;
                        batch_id_r        <= batch_id_r + 32'd1;
                        total_batches_r   <= total_batches_r + 32'd1;
                        timeout_closes_r  <= timeout_closes_r + {31'd0, close_timeout_r};
                        state_r           <= ST_WAIT_EXEC;
                    end
                end

                ST_WAIT_EXEC: begin
                    if (exec_done) begin
                        state_r     <= ST_IDLE;
                        cur_count_r <= 16'd0;
                        idle_cnt_r  <= 16'd0;
                        ready_en_r  <= state_accepts(ST_IDLE);
                    end
                end

                default: begin
                    state_r    <= ST_IDLE;
                    ready_en_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_batch_controller.sv
// Directed table-driven bench for batch_controller (BATCH_SIZE=4, TIMEOUT_CYCLES=10).
module tb_batch_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush;
    logic        exec_done;
    logic        batch_completed;
    logic [31:0] batch_id;
    logic [15:0] batch_count;
    logic [31:0] timeout_closes;
    logic [31:0] total_batches;

    int n_vec = 0;
    int n_bad = 0;

    batch_controller_if bif ();

    batch_controller #(
        .BATCH_SIZE     (4),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .axis            (bif),
        .flush           (flush),
        .exec_done       (exec_done),
        .batch_completed (batch_completed),
        .batch_id        (batch_id),
        .batch_count     (batch_count),
        .timeout_closes  (timeout_closes),
        .total_batches   (total_batches)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        srdy;
        logic        mv;
        logic [63:0] md;
        logic        bc;
        logic [31:0] id;
        logic [15:0] cnt;
        logic [31:0] to;
        logic [31:0] tot;
    } obs_t;

    typedef struct {
        logic        tv;
        logic [63:0] data;
        logic        mr;
        logic        fl;
        logic        ed;
        obs_t        exp;
    } vec_t;

    vec_t tbl[$];

    function automatic obs_t ob(input logic srdy, input logic mv, input logic [63:0] md,
                                input logic bc, input logic [31:0] id, input logic [15:0] cnt,
                                input logic [31:0] to, input logic [31:0] tot);
        obs_t o;
        o.srdy = srdy; o.mv = mv; o.md = md; o.bc = bc;
        o.id = id; o.cnt = cnt; o.to = to; o.tot = tot;
        return o;
    endfunction

    function automatic vec_t mk(input logic tv, input logic [63:0] d, input logic mr,
                                input logic fl, input logic ed, input obs_t e);
        vec_t v;
        v.tv = tv; v.data = d; v.mr = mr; v.fl = fl; v.ed = ed; v.exp = e;
        return v;
    endfunction

    task automatic check(input string nm, input obs_t e);
        obs_t a;
        a.srdy = bif.s_axis_tready;
        a.mv   = bif.m_axis_tvalid;
        a.md   = bif.m_axis_tdata_owner_programID;
        a.bc   = batch_completed;
        a.id   = batch_id;
        a.cnt  = batch_count;
        a.to   = timeout_closes;
        a.tot  = total_batches;
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s got srdy=%0b mv=%0b md=%h bc=%0b id=%0d cnt=%0d to=%0d tot=%0d want srdy=%0b mv=%0b md=%h bc=%0b id=%0d cnt=%0d to=%0d tot=%0d",
                     nm, a.srdy, a.mv, a.md, a.bc, a.id, a.cnt, a.to, a.tot,
                     e.srdy, e.mv, e.md, e.bc, e.id, e.cnt, e.to, e.tot);
        end
    endtask

    task automatic drive_idle();
        bif.s_axis_tvalid                = 1'b0;
        bif.s_axis_tdata_owner_programID = 64'h0;
        bif.m_axis_tready                = 1'b0;
        flush                            = 1'b0;
        exec_done                        = 1'b0;
    endtask

    // Asynchronous reset from wherever the run is, then release and watch tready rise.
    task automatic do_reset(input string nm);
        #1;
        rst_n = 1'b0;
        drive_idle();
        #1 check({nm, "_asserted"}, ob(1'b0, 1'b0, 64'h0, 1'b0, 32'd0, 16'd0, 32'd0, 32'd0));
        repeat (2) @(posedge clk);
        #1 check({nm, "_held"}, ob(1'b0, 1'b0, 64'h0, 1'b0, 32'd0, 16'd0, 32'd0, 32'd0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 check({nm, "_released"}, ob(1'b0, 1'b0, 64'h0, 1'b0, 32'd0, 16'd0, 32'd0, 32'd0));
        @(posedge clk);
        #1 check({nm, "_first_clk"}, ob(1'b1, 1'b0, 64'h0, 1'b0, 32'd0, 16'd0, 32'd0, 32'd0));
    endtask

    task automatic run_tbl(input string tag);
        foreach (tbl[i]) begin
            @(negedge clk);
            bif.s_axis_tvalid                = tbl[i].tv;
            bif.s_axis_tdata_owner_programID = tbl[i].data;
            bif.m_axis_tready                = tbl[i].mr;
            flush                            = tbl[i].fl;
            exec_done                        = tbl[i].ed;
            @(posedge clk);
            #1 check($sformatf("%s[%0d]", tag, i), tbl[i].exp);
        end
        tbl.delete();
    endtask

    initial begin
        drive_idle();
        do_reset("por");

        // Size close, back-to-back IDs 0x10..0x13, flush in IDLE ignored.
        tbl.push_back(mk(1'b0, 64'h0,  1'b1, 1'b0, 1'b0, ob(1'b1, 1'b0, 64'h0,  1'b0, 32'd0, 16'd0, 32'd0, 32'd0)));
        tbl.push_back(mk(1'b0, 64'h0,  1'b1, 1'b1, 1'b0, ob(1'b1, 1'b0, 64'h0,  1'b0, 32'd0, 16'd0, 32'd0, 32'd0)));
        tbl.push_back(mk(1'b1, 64'h10, 1'b1, 1'b0, 1'b0, ob(1'b1, 1'b1, 64'h10, 1'b0, 32'd0, 16'd0, 32'd0, 32'd0)));
        tbl.push_back(mk(1'b1, 64'h11, 1'b1, 1'b0, 1'b0, ob(1'b1, 1'b1, 64'h11, 1'b0, 32'd0, 16'd0, 32'd0, 32'd0)));
        tbl.push_back(mk(1'b1, 64'h12, 1'b1, 1'b0, 1'b0, ob(1'b1, 1'b1, 64'h12, 1'b0, 32'd0, 16'd0, 32'd0, 32'd0)));
        tbl.push_back(mk(1'b1, 64'h13, 1'b1, 1'b0, 1'b0, ob(1'b0, 1'b1, 64'h13, 1'b0, 32'd0, 16'd0, 32'd0, 32'd0)));
        tbl.push_back(mk(1'b0, 64'h0,  1'b1, 1'b0, 1'b0, ob(1'b0, 1'b0, 64'h13, 1'b1, 32'd1, 16'd4, 32'd0, 32'd1)));
        tbl.push_back(mk(1'b1, 64'h99, 1'b1, 1'b0, 1'b0, ob(1'b0, 1'b0, 64'h13, 1'b0, 32'd1, 16'd4, 32'd0, 32'd1)));
        tbl.push_back(mk(1'b0, 64'h0,  1'b1, 1'b0, 1'b1, ob(1'b1, 1'b0, 64'h13, 1'b0, 32'd1, 16'd4, 32'd0, 32'd1)));

        // Timeout close: two accepts, DRAIN entered 10 idle cycles later.
        tbl.push_back(mk(1'b1, 64'h20, 1'b1, 1'b0, 1'b0, ob(1'b1, 1'b1, 64'h20, 1'b0, 32'd1, 16'd4, 32'd0, 32'd1)));
        tbl.push_back(mk(1'b1, 64'h21, 1'b1, 1'b0, 1'b0, ob(1'b1, 1'b1, 64'h21, 1'b0, 32'd1, 16'd4, 32'd0, 32'd1)));
        for (int k = 0; k < 9; k++)
            tbl.push_back(mk(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, ob(1'b1, 1'b0, 64'h21, 1'b0, 32'd1, 16'd4, 32'd0, 32'd1)));
        tbl.push_back(mk(1'b0, 64'h0,  1'b1, 1'b0, 1'b0, ob(1'b0, 1'b0, 64'h21, 1'b0, 32'd1, 16'd4, 32'd0, 32'd1)));
        tbl.push_back(mk(1'b0, 64'h0,  1'b1, 1'b0, 1'b0, ob(1'b0, 1'b0, 64'h21, 1'b1, 32'd2, 16'd2, 32'd1, 32'd2)));
        tbl.push_back(mk(1'b0, 64'h0,  1'b1, 1'b0, 1'b1, ob(1'b1, 1'b0, 64'h21, 1'b0, 32'd2, 16'd2, 32'd1, 32'd2)));

        // Accepts landing on the timeout cycle restart the timer; then a flush close with 3.
        tbl.push_back(mk(1'b1, 64'h30, 1'b1, 1'b0, 1'b0, ob(1'b1, 1'b1, 64'h30, 1'b0, 32'd2, 16'd2, 32'd1, 32'd2)));
        for (int k = 0; k < 9; k++)
            tbl.push_back(mk(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, ob(1'b1, 1'b0, 64'h30, 1'b0, 32'd2, 16'd2, 32'd1, 32'd2)));
        tbl.push_back(mk(1'b1, 64'h31, 1'b1, 1'b0, 1'b0, ob(1'b1, 1'b1, 64'h31, 1'b0, 32'd2, 16'd2, 32'd1, 32'd2)));
        for (int k = 0; k < 9; k++)
            tbl.push_back(mk(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, ob(1'b1, 1'b0, 64'h31, 1'b0, 32'd2, 16'd2, 32'd1, 32'd2)));
        tbl.push_back(mk(1'b1, 64'h32, 1'b1, 1'b1, 1'b0, ob(1'b1, 1'b1, 64'h32, 1'b0, 32'd2, 16'd2, 32'd1, 32'd2)));
        tbl.push_back(mk(1'b0, 64'h0,  1'b1, 1'b1, 1'b0, ob(1'b0, 1'b0, 64'h32, 1'b0, 32'd2, 16'd2, 32'd1, 32'd2)));
        tbl.push_back(mk(1'b0, 64'h0,  1'b1, 1'b0, 1'b0, ob(1'b0, 1'b0, 64'h32, 1'b1, 32'd3, 16'd3, 32'd1, 32'd3)));
        tbl.push_back(mk(1'b0, 64'h0,  1'b1, 1'b0, 1'b1, ob(1'b1, 1'b0, 64'h32, 1'b0, 32'd3, 16'd3, 32'd1, 32'd3)));

        // Size close under 5 cycles of back-pressure; exec_done in DRAIN ignored.
        tbl.push_back(mk(1'b1, 64'h40, 1'b1, 1'b0, 1'b0, ob(1'b1, 1'b1, 64'h40, 1'b0, 32'd3, 16'd3, 32'd1, 32'd3)));
        tbl.push_back(mk(1'b1, 64'h41, 1'b1, 1'b0, 1'b0, ob(1'b1, 1'b1, 64'h41, 1'b0, 32'd3, 16'd3, 32'd1, 32'd3)));
        tbl.push_back(mk(1'b1, 64'h42, 1'b1, 1'b0, 1'b0, ob(1'b1, 1'b1, 64'h42, 1'b0, 32'd3, 16'd3, 32'd1, 32'd3)));
        tbl.push_back(mk(1'b1, 64'h43, 1'b1, 1'b0, 1'b0, ob(1'b0, 1'b1, 64'h43, 1'b0, 32'd3, 16'd3, 32'd1, 32'd3)));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(1'b0, 64'h0, 1'b0, 1'b0, (k == 2) ? 1'b1 : 1'b0,
                             ob(1'b0, 1'b1, 64'h43, 1'b0, 32'd3, 16'd3, 32'd1, 32'd3)));
        tbl.push_back(mk(1'b0, 64'h0,  1'b1, 1'b0, 1'b0, ob(1'b0, 1'b0, 64'h43, 1'b1, 32'd4, 16'd4, 32'd1, 32'd4)));
        tbl.push_back(mk(1'b0, 64'h0,  1'b1, 1'b0, 1'b1, ob(1'b1, 1'b0, 64'h43, 1'b0, 32'd4, 16'd4, 32'd1, 32'd4)));

        // Back-pressure while collecting, then accept+handshake in one cycle.
        tbl.push_back(mk(1'b1, 64'h50, 1'b1, 1'b0, 1'b0, ob(1'b1, 1'b1, 64'h50, 1'b0, 32'd4, 16'd4, 32'd1, 32'd4)));
        tbl.push_back(mk(1'b1, 64'h51, 1'b0, 1'b0, 1'b0, ob(1'b0, 1'b1, 64'h50, 1'b0, 32'd4, 16'd4, 32'd1, 32'd4)));
        tbl.push_back(mk(1'b1, 64'h51, 1'b1, 1'b0, 1'b0, ob(1'b1, 1'b1, 64'h51, 1'b0, 32'd4, 16'd4, 32'd1, 32'd4)));
        tbl.push_back(mk(1'b1, 64'h52, 1'b1, 1'b0, 1'b0, ob(1'b1, 1'b1, 64'h52, 1'b0, 32'd4, 16'd4, 32'd1, 32'd4)));
        run_tbl("main");

        // Reset with three transactions in the batch; numbering restarts at 1.
        do_reset("mid_batch");
        tbl.push_back(mk(1'b0, 64'h0,  1'b1, 1'b0, 1'b0, ob(1'b1, 1'b0, 64'h0,  1'b0, 32'd0, 16'd0, 32'd0, 32'd0)));
        tbl.push_back(mk(1'b1, 64'h60, 1'b1, 1'b0, 1'b0, ob(1'b1, 1'b1, 64'h60, 1'b0, 32'd0, 16'd0, 32'd0, 32'd0)));
        tbl.push_back(mk(1'b1, 64'h61, 1'b1, 1'b0, 1'b0, ob(1'b1, 1'b1, 64'h61, 1'b0, 32'd0, 16'd0, 32'd0, 32'd0)));
        tbl.push_back(mk(1'b1, 64'h62, 1'b1, 1'b0, 1'b0, ob(1'b1, 1'b1, 64'h62, 1'b0, 32'd0, 16'd0, 32'd0, 32'd0)));
        tbl.push_back(mk(1'b1, 64'h63, 1'b1, 1'b0, 1'b0, ob(1'b0, 1'b1, 64'h63, 1'b0, 32'd0, 16'd0, 32'd0, 32'd0)));
        tbl.push_back(mk(1'b0, 64'h0,  1'b1, 1'b0, 1'b0, ob(1'b0, 1'b0, 64'h63, 1'b1, 32'd1, 16'd4, 32'd0, 32'd1)));
        tbl.push_back(mk(1'b0, 64'h0,  1'b1, 1'b0, 1'b1, ob(1'b1, 1'b0, 64'h63, 1'b0, 32'd1, 16'd4, 32'd0, 32'd1)));
        run_tbl("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
